// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port RAM arbiter for loader / fetch / data requesters.
// One transaction in flight: IDLE picks a winner, ACCESS drives the RAM for one
// cycle, WAIT rides out the RAM read latency, RESP hands read data back.
module mem_port_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          da_req,
  input  logic          da_we,
  input  logic [AW-1:0] da_addr,
  input  logic [DW-1:0] da_wdata,
  output logic          da_gnt,
  output logic          da_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_LD, OWN_IF, OWN_DA} owner_t;

  // Latency counter preload; MEM_LAT is limited to 1..4 so it fits in 2 bits.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t        state, state_nxt;
  owner_t        owner;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_we;
  logic          last_da;   // 1: DA was the last IF/DA winner
  logic [1:0]    cnt;

  owner_t        win;
  logic          win_vld;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_we;

  logic          in_access;
  logic          in_resp;
  logic          cap_now;

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);
  assign cap_now   = (state == WAIT) && (cnt == 2'd0);

  // Winner selection: loader is absolute priority; IF/DA tie goes to the one
  // that did not win last time.
  always_comb begin
    win       = OWN_LD;
    win_vld   = 1'b0;
    win_addr  = ld_addr;
    win_wdata = ld_wdata;
    win_we    = 1'b1;
    if (ld_req) begin
      win_vld = 1'b1;
    end else if (if_req && (!da_req || last_da)) begin
      win       = OWN_IF;
      win_vld   = 1'b1;
      win_addr  = if_addr;
      win_wdata = '0;
      win_we    = 1'b0;
    end else if (da_req) begin
      win       = OWN_DA;
      win_vld   = 1'b1;
      win_addr  = da_addr;
      win_wdata = da_wdata;
      win_we    = da_we;
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = req_we ? IDLE : WAIT;
      WAIT:    if (cnt == 2'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the winning request; the requester's fields are ignored afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_LD;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
    end else if (state == IDLE && win_vld) begin
      owner     <= win;
      req_addr  <= win_addr;
      req_wdata <= win_wdata;
      req_we    <= win_we;
    end
  end

  // Round-robin history; loader grants leave it untouched.
  always_ff @(posedge clk) begin
    if (rst)
      last_da <= 1'b1;
    else if (state == IDLE && win_vld && win != OWN_LD)
      last_da <= (win == OWN_DA);
  end

  // Read-latency down-counter, preloaded as the read leaves ACCESS.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 2'd0;
    else if (in_access)
      cnt <= CNT_INIT;
    else if (state == WAIT && cnt != 2'd0)
      cnt <= cnt - 2'd1;
  end

  // Read data capture; holds until the next read lands.
  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (cap_now)
      rdata <= mem_rdata;
  end

  // RAM pins are quiet outside ACCESS so an aborted access never leaks out.
  assign mem_en    = in_access;
  assign mem_we    = in_access && req_we;
  assign mem_addr  = in_access ? req_addr  : '0;
  assign mem_wdata = in_access ? req_wdata : '0;

  assign ld_gnt    = in_access && (owner == OWN_LD);
  assign if_gnt    = in_access && (owner == OWN_IF);
  assign da_gnt    = in_access && (owner == OWN_DA);
  assign if_rvalid = in_resp   && (owner == OWN_IF);
  assign da_rvalid = in_resp   && (owner == OWN_DA);

  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model with exact read latency plus a
// transaction-level reference (priority rules, expected cycles, shadow memory).
module tb_mem_port_arbiter;
  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_req, if_req, da_req, da_we;
  logic [AW-1:0] ld_addr, if_addr, da_addr;
  logic [DW-1:0] ld_wdata, da_wdata;
  logic          ld_gnt, if_gnt, da_gnt, if_rvalid, da_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] ref_mem [32];
  logic          ref_last_da;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .da_req(da_req), .da_we(da_we), .da_addr(da_addr), .da_wdata(da_wdata),
    .da_gnt(da_gnt), .da_rvalid(da_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // RAM model: read data appears exactly LAT cycles after the enable cycle,
  // junk otherwise so a mistimed capture is visible.
  logic [DW-1:0] ram [32];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : DW'($urandom);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic idle_inputs();
    ld_req = 0; if_req = 0; da_req = 0; da_we = 0;
    ld_addr = '0; if_addr = '0; da_addr = '0; ld_wdata = '0; da_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    ref_last_da = 1'b1;
  endtask

  // Loader write with a bounded wait for the grant (drive only).
  task automatic lw(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
    ok = 0;
    ld_req = 1; ld_addr = a; ld_wdata = d;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge clk);
      if (ld_gnt) ok = 1;
    end
    ld_req = 0;
    @(negedge clk);
    if (ok) ref_mem[a] = d;
  endtask

  task automatic test_reset();
    rst = 1; ld_req = 1; if_req = 1; da_req = 1; da_we = 0;
    ld_addr = 5'd7; ld_wdata = 8'h77; if_addr = 5'd3; da_addr = 5'd4; da_wdata = 8'h44;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if ({ld_gnt, if_gnt, da_gnt, if_rvalid, da_rvalid, mem_en, mem_we, busy} !== 8'b0 ||
          mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
        n_fail++;
        $display("FAIL reset_state: gnt=%b%b%b rv=%b%b en=%b we=%b busy=%b addr=%0d wd=%h rd=%h, want all 0",
                 ld_gnt, if_gnt, da_gnt, if_rvalid, da_rvalid, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata);
      end
    end
    rst = 0;
    @(negedge clk);
    n_chk++;
    if ({ld_gnt, if_gnt, da_gnt} !== 3'b100 || mem_we !== 1'b1 || mem_addr !== 5'd7 || mem_wdata !== 8'h77) begin
      n_fail++;
      $display("FAIL reset_first_grant: gnt(ld,if,da)=%b%b%b we=%b addr=%0d wd=%h, want 100 1 7 77",
               ld_gnt, if_gnt, da_gnt, mem_we, mem_addr, mem_wdata);
    end
    idle_inputs();
    ref_mem[7] = 8'h77;
    ref_last_da = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_after_write_busy: got %b want 0", busy); end
  endtask

  task automatic test_init();
    bit ok;
    bit all_ok = 1;
    for (int a = 0; a < 32; a++) begin
      lw(AW'(a), DW'($urandom), ok);
      all_ok &= ok;
    end
    n_chk++;
    if (!all_ok) begin n_fail++; $display("FAIL init_loader_grants: some loader write got no grant"); end
  endtask

  task automatic test_if_read();
    bit ok;
    lw(5'd5, 8'hA3, ok);
    if_req = 1; if_addr = 5'd5;
    for (int c = 1; c <= 3 + LAT; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_chk++;
        if ({ld_gnt, if_gnt, da_gnt} !== 3'b010 || mem_en !== 1 || mem_we !== 0 || mem_addr !== 5'd5) begin
          n_fail++;
          $display("FAIL if_read_grant: gnt=%b%b%b en=%b we=%b addr=%0d, want 010 1 0 5",
                   ld_gnt, if_gnt, da_gnt, mem_en, mem_we, mem_addr);
        end
        if_req = 0;
      end else begin
        n_chk++;
        if (if_rvalid !== (c == 2 + LAT) || da_rvalid !== 0 || busy !== (c <= 2 + LAT)) begin
          n_fail++;
          $display("FAIL if_read_cycle%0d: if_rv=%b da_rv=%b busy=%b", c, if_rvalid, da_rvalid, busy);
        end
        if (c == 2 + LAT) begin
          n_chk++;
          if (rdata !== 8'hA3) begin n_fail++; $display("FAIL if_read_data: got %h want a3", rdata); end
        end
      end
    end
    ref_last_da = 1'b0;
  endtask

  task automatic test_da_write_if_read();
    da_req = 1; da_we = 1; da_addr = 5'd31; da_wdata = 8'h5C;
    @(negedge clk);
    n_chk++;
    if ({ld_gnt, if_gnt, da_gnt} !== 3'b001 || mem_en !== 1 || mem_we !== 1 ||
        mem_addr !== 5'd31 || mem_wdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL da_write_grant: gnt=%b%b%b en=%b we=%b addr=%0d wd=%h, want 001 1 1 31 5c",
               ld_gnt, if_gnt, da_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    idle_inputs();
    ref_mem[31] = 8'h5C;
    ref_last_da = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 0 || da_rvalid !== 0) begin
      n_fail++; $display("FAIL da_write_done: busy=%b da_rv=%b want 0 0", busy, da_rvalid);
    end
    if_req = 1; if_addr = 5'd31;
    for (int c = 1; c <= 3 + LAT; c++) begin
      @(negedge clk);
      if (c == 1) if_req = 0;
      if (c == 2 + LAT) begin
        n_chk++;
        if (if_rvalid !== 1 || rdata !== 8'h5C) begin
          n_fail++; $display("FAIL da_write_readback: rv=%b rdata=%h want 1 5c", if_rvalid, rdata);
        end
      end
    end
    ref_last_da = 1'b0;
  endtask

  task automatic test_round_robin();
    int g = 0;
    int r = 0;
    int q[$];
    int act, exp_o;
    do_reset();
    if_req = 1; if_addr = 5'd10; da_req = 1; da_we = 0; da_addr = 5'd20;
    for (int c = 0; c < 80 && r < 4; c++) begin
      @(negedge clk);
      if (if_gnt || da_gnt || ld_gnt) begin
        act = ld_gnt ? 0 : (if_gnt && da_gnt) ? 3 : if_gnt ? 1 : 2;
        exp_o = (g % 2 == 0) ? 1 : 2;
        n_chk++;
        if (act !== exp_o) begin n_fail++; $display("FAIL rr_grant%0d: got owner %0d want %0d", g, act, exp_o); end
        q.push_back(exp_o);
        g++;
        if (g == 4) begin if_req = 0; da_req = 0; end
      end
      if (if_rvalid || da_rvalid) begin
        exp_o = (q.size() > 0) ? q.pop_front() : 0;
        act = (if_rvalid && da_rvalid) ? 3 : if_rvalid ? 1 : 2;
        n_chk++;
        if (act !== exp_o || rdata !== ref_mem[(exp_o == 1) ? 10 : 20]) begin
          n_fail++;
          $display("FAIL rr_rvalid%0d: owner %0d data %h, want owner %0d data %h",
                   r, act, rdata, exp_o, ref_mem[(exp_o == 1) ? 10 : 20]);
        end
        r++;
      end
    end
    n_chk++;
    if (r != 4) begin n_fail++; $display("FAIL rr_timeout: got %0d responses want 4", r); end
    idle_inputs();
    @(negedge clk);
    ref_last_da = 1'b1;
  endtask

  task automatic test_loader_priority();
    logic [DW-1:0] dat [3];
    int k = 0;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
    ld_req = 1; ld_addr = 5'd0; ld_wdata = dat[0];
    if_req = 1; if_addr = 5'd2;
    for (int c = 1; c <= 9 + LAT; c++) begin
      @(negedge clk);
      n_chk++;
      if (ld_gnt !== (c == 1 || c == 3 || c == 5) || if_gnt !== (c == 7) || da_gnt !== 0) begin
        n_fail++;
        $display("FAIL ld_prio_cycle%0d: ld_gnt=%b if_gnt=%b da_gnt=%b", c, ld_gnt, if_gnt, da_gnt);
      end
      if (ld_gnt) begin
        ref_mem[k] = dat[k];
        k++;
        if (k < 3) begin ld_addr = AW'(k); ld_wdata = dat[k]; end
        else ld_req = 0;
      end
      if (if_gnt) if_req = 0;
      if (c == 8 + LAT) begin
        n_chk++;
        if (if_rvalid !== 1 || rdata !== 8'h33) begin
          n_fail++; $display("FAIL ld_prio_readback: rv=%b rdata=%h want 1 33", if_rvalid, rdata);
        end
      end
    end
    n_chk++;
    if (busy !== 0 || ram[0] !== 8'h11 || ram[1] !== 8'h22) begin
      n_fail++; $display("FAIL ld_prio_ram: busy=%b ram0=%h ram1=%h want 0 11 22", busy, ram[0], ram[1]);
    end
    idle_inputs();
    ref_last_da = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    da_req = 1; da_we = 0; da_addr = 5'd9;
    @(negedge clk);
    n_chk++;
    if (da_gnt !== 1) begin n_fail++; $display("FAIL midrst_da_grant: got %b want 1", da_gnt); end
    da_req = 0;
    @(negedge clk);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    n_chk++;
    if (busy !== 0 || mem_en !== 0) begin n_fail++; $display("FAIL midrst_busy: busy=%b en=%b want 0 0", busy, mem_en); end
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (da_rvalid !== 0 || if_rvalid !== 0 || busy !== 0) begin
        n_fail++; $display("FAIL midrst_quiet%0d: da_rv=%b if_rv=%b busy=%b", c, da_rvalid, if_rvalid, busy);
      end
    end
    // Abort an IF read so history says IF, then reset must hand the next tie to IF.
    if_req = 1; if_addr = 5'd9;
    @(negedge clk); if_req = 0;
    rst = 1;
    @(negedge clk); rst = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (if_rvalid !== 0 || busy !== 0) begin
        n_fail++; $display("FAIL midrst_if_quiet%0d: if_rv=%b busy=%b", c, if_rvalid, busy);
      end
    end
    if_req = 1; da_req = 1; da_we = 0; if_addr = 5'd1; da_addr = 5'd2;
    @(negedge clk);
    n_chk++;
    if ({if_gnt, da_gnt} !== 2'b10) begin n_fail++; $display("FAIL midrst_tie: if/da gnt=%b%b want 10", if_gnt, da_gnt); end
    idle_inputs();
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    ref_last_da = 1'b0;
  endtask

  task automatic test_random();
    bit l, i, d, dwe, wr;
    int w;
    logic [AW-1:0] la, ia, dadr, ea;
    logic [DW-1:0] lwd, dwd, ed;
    for (int it = 0; it < 40; it++) begin
      l = ($urandom_range(3) == 0); i = $urandom_range(1); d = $urandom_range(1); dwe = $urandom_range(1);
      if (!l && !i && !d) i = 1;
      la = AW'($urandom); ia = AW'($urandom); dadr = AW'($urandom);
      lwd = DW'($urandom); dwd = DW'($urandom);
      if (l) w = 0;
      else if (i && (!d || ref_last_da)) w = 1;
      else w = 2;
      wr = (w == 0) || (w == 2 && dwe);
      ea = (w == 0) ? la : (w == 1) ? ia : dadr;
      ed = (w == 0) ? lwd : dwd;
      if (w != 0) ref_last_da = (w == 2);
      ld_req = l; ld_addr = la; ld_wdata = lwd;
      if_req = i; if_addr = ia;
      da_req = d; da_we = dwe; da_addr = dadr; da_wdata = dwd;
      @(negedge clk);
      n_chk++;
      if ({ld_gnt, if_gnt, da_gnt} !== (3'b100 >> w) || mem_en !== 1 || mem_we !== wr ||
          mem_addr !== ea || (wr && mem_wdata !== ed)) begin
        n_fail++;
        $display("FAIL rand%0d_grant: gnt=%b%b%b we=%b addr=%0d wd=%h, want %b %b %0d %h",
                 it, ld_gnt, if_gnt, da_gnt, mem_we, mem_addr, mem_wdata, 3'b100 >> w, wr, ea, ed);
      end
      idle_inputs();
      if (wr) begin
        ref_mem[ea] = ed;
        @(negedge clk);
        n_chk++;
        if (busy !== 0) begin n_fail++; $display("FAIL rand%0d_wr_busy: got %b want 0", it, busy); end
      end else begin
        for (int c = 2; c <= 3 + LAT; c++) begin
          @(negedge clk);
          n_chk++;
          if ({if_rvalid, da_rvalid} !== ((c == 2 + LAT) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00) ||
              busy !== (c <= 2 + LAT) || (c == 2 + LAT && rdata !== ref_mem[ea])) begin
            n_fail++;
            $display("FAIL rand%0d_rd_c%0d: rv(if,da)=%b%b busy=%b rdata=%h want data %h",
                     it, c, if_rvalid, da_rvalid, busy, rdata, ref_mem[ea]);
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    ref_last_da = 1'b1;
    test_reset();
    test_init();
    test_if_read();
    test_da_write_if_read();
    test_round_robin();
    test_loader_priority();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
